// File: rtl/multicore_system_multitimer_pkg.sv
// multitimer_pkg: register map and bit positions shared by the multi-channel timer
package multitimer_pkg;
   localparam int REG_STATUS    = 0;
   localparam int REG_CONTROL   = 1;
   localparam int REG_PERIOD    = 2;
   localparam int REG_SNAP      = 3;
   localparam int CTL_ITO       = 0;
   localparam int CTL_CONT      = 1;
   localparam int CTL_START     = 2;
   localparam int CTL_STOP      = 3;
   localparam int CTL_PRESC_LSB = 8;
   localparam int ST_TO         = 0;
   localparam int ST_RUN        = 1;
endpackage

// File: rtl/multicore_system_multitimer_if.sv
// multicore_system_multitimer_if: Avalon-MM slave bus plus interrupt line of the timer block
interface multicore_system_multitimer_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
   modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/multicore_system_multitimer_channel.sv
// multicore_system_multitimer_channel: one prescaled down-counter with snapshot and sticky timeout
module multicore_system_multitimer_channel
   import multitimer_pkg::*;
#(
   parameter int          CNT_W        = 32,
   parameter int          PRESC_W      = 8,
   parameter int unsigned RESET_PERIOD = 49999
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [3:0]      i_we,
   input  logic [31:0]     i_wdata,
   output logic [3:0][31:0] o_rd,
   output logic            o_irq
);
   localparam int PW = PRESC_W > 0 ? PRESC_W : 1;
   logic [CNT_W-1:0] r_cnt, r_period, r_snap;
   logic [PW-1:0]    r_presc, r_pcnt;
   logic             r_run, r_to, r_ito, r_cont, r_reload;
   logic             w_tick, w_zero, w_tmo, w_start, w_stop;
   logic [PW-1:0]    w_presc_wr;
   // a pending force reload suppresses the tick so no timeout can fire that cycle
   assign w_tick     = r_run & ~r_reload & (r_pcnt == r_presc);
   assign w_zero     = r_cnt == '0;
   assign w_tmo      = w_tick & w_zero;
   assign w_start    = i_we[REG_CONTROL] & i_wdata[CTL_START];
   assign w_stop     = i_we[REG_CONTROL] & i_wdata[CTL_STOP];
   assign w_presc_wr = PRESC_W > 0 ? PW'(i_wdata >> CTL_PRESC_LSB) : '0;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= CNT_W'(RESET_PERIOD);
         r_period <= CNT_W'(RESET_PERIOD);
         r_snap   <= '0;
         r_presc  <= '0;
         r_pcnt   <= '0;
         r_run    <= 1'b0;
         r_to     <= 1'b0;
         r_ito    <= 1'b0;
         r_cont   <= 1'b0;
         r_reload <= 1'b0;
      end else begin
         r_reload <= i_we[REG_PERIOD];
         r_to     <= w_tmo | (r_to & ~(i_we[REG_STATUS] & i_wdata[ST_TO]));
         if (i_we[REG_PERIOD]) r_period <= CNT_W'(i_wdata);
         if (i_we[REG_SNAP]) r_snap <= r_cnt;
         if (i_we[REG_CONTROL]) begin
            r_ito   <= i_wdata[CTL_ITO];
            r_cont  <= i_wdata[CTL_CONT];
            r_presc <= w_presc_wr;
         end
         if (r_reload) begin
            r_cnt  <= r_period;
            r_pcnt <= '0;
         end else if (w_tick) begin
            r_cnt  <= w_zero ? r_period : r_cnt - 1'b1;
            r_pcnt <= '0;
         end else if (r_run) begin
            r_pcnt <= r_pcnt + 1'b1;
         end
         // START outranks STOP, reload and a one-shot expiry in the same cycle
         if (w_start) begin
            r_run  <= 1'b1;
            r_pcnt <= '0;
         end else if (w_stop | r_reload | (w_tmo & ~r_cont)) begin
            r_run <= 1'b0;
         end
      end
   end
   always_comb begin
      o_rd              = '0;
      o_rd[REG_STATUS]  = (32'(r_run) << ST_RUN) | (32'(r_to) << ST_TO);
      o_rd[REG_CONTROL] = (32'(r_presc) << CTL_PRESC_LSB) | (32'(r_cont) << CTL_CONT) | (32'(r_ito) << CTL_ITO);
      o_rd[REG_PERIOD]  = 32'(r_period);
      o_rd[REG_SNAP]    = 32'(r_snap);
   end
   assign o_irq = r_to & r_ito;
endmodule

// File: rtl/multicore_system_multitimer.sv
// multicore_system_multitimer: NUM_CH interval timers behind one Avalon-MM slave with a shared irq
module multicore_system_multitimer
   import multitimer_pkg::*;
#(
   parameter int          NUM_CH       = 4,
   parameter int          CNT_W        = 32,
   parameter int          PRESC_W      = 8,
   parameter int unsigned RESET_PERIOD = 49999,
   parameter int          ADDR_W       = $clog2(NUM_CH) + 2
) (
   input logic                          clk,
   input logic                          reset_n,
   multicore_system_multitimer_if.slave bus
);
   logic [ADDR_W-1:0]            w_ch;
   logic [1:0]                   w_reg;
   logic                         w_wr;
   logic [NUM_CH-1:0][3:0][31:0] w_rd;
   logic [NUM_CH-1:0]            w_irq;
   logic [31:0]                  w_rdata;
   logic [31:0]                  r_rdata;
   assign w_ch  = bus.address >> 2;
   assign w_reg = bus.address[1:0];
   assign w_wr  = bus.chipselect & ~bus.write_n;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [3:0] w_we;
      assign w_we = (w_wr && w_ch == ADDR_W'(i)) ? 4'b0001 << w_reg : 4'b0000;
      multicore_system_multitimer_channel #(
         .CNT_W(CNT_W), .PRESC_W(PRESC_W), .RESET_PERIOD(RESET_PERIOD)
      ) u_ch (
         .clk(clk), .reset_n(reset_n), .i_we(w_we), .i_wdata(bus.writedata),
         .o_rd(w_rd[i]), .o_irq(w_irq[i])
      );
   end
   // channel indices with no instance fall through to zero
   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < NUM_CH; k++) w_rdata = (w_ch == ADDR_W'(k)) ? w_rd[k][w_reg] : w_rdata;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rdata <= '0;
      else r_rdata <= w_rdata;
   end
   assign bus.readdata = r_rdata;
   assign bus.irq      = |w_irq;
endmodule
